dds_lut_scheduler: RTL and testbench
====================================

DDS_LUT_SCHEDULER -- requirements
Module: dds_lut_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, number of DDS channels sharing one sine LUT.
REQ-002 SHALL have parameter ACC_W, default 24, per-channel phase accumulator width.
REQ-003 SHALL have parameter PH_W, default 14, LUT phase width.
REQ-004 SHALL have parameter SIN_W, default 12, LUT sample width.
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 tick  in  1  sample-rate strobe; requests one sweep of all channels.
REQ-009 ch_en  in  NCH  per-channel enable.
REQ-010 cfg_we  in  1  tuning-word write strobe.
REQ-011 cfg_clr  in  1  phase-accumulator clear strobe.
REQ-012 cfg_addr  in  clog2(NCH)  target channel for cfg_we/cfg_clr.
REQ-013 cfg_data  in  ACC_W  frequency tuning word (FTW).
REQ-014 ovr_clr  in  1  clears sticky overrun.
REQ-015 lut_phase  out  PH_W  phase to the shared combinational sine LUT.
REQ-016 lut_sine  in  SIN_W  LUT result, valid in the same cycle as lut_phase.
REQ-017 sample_data  out  NCH*SIN_W  per-channel held samples; channel c at bits [c*SIN_W +: SIN_W].
REQ-018 sample_valid  out  NCH  one-cycle pulse per channel when its sample updates.
REQ-019 busy  out  1  high while the sweep is in progress.
REQ-020 frame_done  out  1  one-cycle pulse after the last slot of a sweep.
REQ-021 overrun  out  1  sticky flag: tick arrived while busy.

Function
REQ-022 SHALL implement FSM states IDLE and SWEEP; IDLE->SWEEP on tick, SWEEP->IDLE after slot NCH-1.
REQ-023 SHALL hold slot counter at 0 on entry to SWEEP and increment it once per cycle, 0..NCH-1.
REQ-024 In SWEEP, lut_phase SHALL equal acc[slot][ACC_W-1 -: PH_W]; in IDLE, lut_phase SHALL be 0.
REQ-025 At the edge ending slot c with ch_en[c]=1: sample[c]<=lut_sine, acc[c]<=acc[c]+ftw[c] modulo 2^ACC_W, sample_valid[c] high for the next cycle.
REQ-026 With ch_en[c]=0 at its slot: acc[c], sample[c] hold; no sample_valid[c] pulse.
REQ-027 Latency: tick sampled at edge E0; channel c captured at edge E(c+1); frame_done high for the cycle after E(NCH).
REQ-028 busy SHALL equal (state==SWEEP).
REQ-029 A tick while busy SHALL be dropped and set overrun; a tick in the same cycle frame_done is high SHALL start a new sweep.
REQ-030 cfg_we SHALL write ftw[cfg_addr] at any time; if it coincides with that channel's accumulate, the accumulate uses the old FTW.
REQ-031 cfg_clr SHALL zero acc[cfg_addr]; if it coincides with that channel's accumulate, the clear wins.
REQ-032 cfg_we and cfg_clr together SHALL both take effect.
REQ-033 ovr_clr SHALL clear overrun; if a new overrun occurs in the same cycle, set wins.
REQ-034 Accumulator wrap SHALL be silent (no flag).

Reset
REQ-035 On rst_n low: state=IDLE, slot=0, all acc=0, all ftw=0, all sample=0, sample_valid=0, frame_done=0, overrun=0, busy=0, lut_phase=0.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep immediately; no partial-sweep pulses after release.

Structure
REQ-037 Shared package dds_pkg SHALL hold NCH, ACC_W, PH_W, SIN_W defaults and the FSM state typedef.
REQ-038 A sub-module dds_chan_acc (one accumulator+FTW register with clear/write/step priority) SHALL be instantiated NCH times; the LUT stays outside this block.

Verification
REQ-039 ftw[0]=0x000400, ch_en=4'b0001, 3 ticks -> lut_phase in slot 0 reads 0,1,2; sample_valid[0] 3 pulses, no others.
REQ-040 Single tick, all enabled -> sample_valid pulses 0001,0010,0100,1000 at E1..E4; frame_done at cycle after E4; busy high 4 cycles.
REQ-041 tick at E0 and E2 -> overrun=1, only one sweep; ovr_clr -> overrun=0.
REQ-042 ftw[1]=0xFFFFFF, acc[1]=0xFFFFFF after 1 step; next step -> acc[1]=0xFFFFFE (wrap), no flag.
REQ-043 cfg_clr for channel 2 at its accumulate edge -> acc[2]=0; cfg_we same edge -> new FTW used on the following sweep only.
REQ-044 rst_n low at E2 of a sweep -> all outputs 0, state IDLE; no sample_valid until the next tick.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared defaults and FSM state type for the multi-channel DDS LUT scheduler.
package dds_pkg;

  localparam int unsigned DDS_NCH   = 4;
  localparam int unsigned DDS_ACC_W = 24;
  localparam int unsigned DDS_PH_W  = 14;
  localparam int unsigned DDS_SIN_W = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } dds_state_e;

endpackage

// File: rtl/dds_chan_acc.sv
// One DDS channel: tuning-word register plus phase accumulator.
// Clear beats step; a step always uses the tuning word held before this edge.
module dds_chan_acc
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W = DDS_ACC_W,
  parameter int unsigned PH_W  = DDS_PH_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [ACC_W-1:0] ftw_i,
  output logic [PH_W-1:0]  phase_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = acc_q + ftw_q;
    end
    ftw_d = we_i ? ftw_i : ftw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ftw_q <= '0;
    end else begin
      acc_q <= acc_d;
      ftw_q <= ftw_d;
    end
  end

  assign phase_o = acc_q[ACC_W-1 -: PH_W];

endmodule

// File: rtl/dds_lut_scheduler.sv
// Time-multiplexes one combinational sine LUT across NCH phase accumulators,
// visiting one channel per cycle on each sample-rate tick.
module dds_lut_scheduler
  import dds_pkg::*;
#(
  parameter  int unsigned NCH   = DDS_NCH,
  parameter  int unsigned ACC_W = DDS_ACC_W,
  parameter  int unsigned PH_W  = DDS_PH_W,
  parameter  int unsigned SIN_W = DDS_SIN_W,
  localparam int unsigned AW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 cfg_we,
  input  logic                 cfg_clr,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [ACC_W-1:0]     cfg_data,
  input  logic                 ovr_clr,
  output logic [PH_W-1:0]      lut_phase,
  input  logic [SIN_W-1:0]     lut_sine,
  output logic [NCH*SIN_W-1:0] sample_data,
  output logic [NCH-1:0]       sample_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  dds_state_e       state_q;
  logic [AW-1:0]    slot_q;
  logic [NCH-1:0]   sample_valid_q;
  logic             frame_done_q;
  logic             overrun_q, overrun_d;
  logic [NCH-1:0]   step;
  logic [PH_W-1:0]  phase [NCH];
  logic [SIN_W-1:0] sample_q [NCH];
  logic             sweep;
  logic             last_slot;

  assign sweep     = (state_q == ST_SWEEP);
  assign last_slot = (slot_q == AW'(NCH - 1));

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign step[c] = sweep && (slot_q == AW'(c)) && ch_en[c];

    dds_chan_acc #(
      .ACC_W (ACC_W),
      .PH_W  (PH_W)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (step[c]),
      .clr_i   (cfg_clr && (cfg_addr == AW'(c))),
      .we_i    (cfg_we && (cfg_addr == AW'(c))),
      .ftw_i   (cfg_data),
      .phase_o (phase[c])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sample_q[c] <= '0;
      end else if (step[c]) begin
        sample_q[c] <= lut_sine;
      end
    end

    assign sample_data[c*SIN_W +: SIN_W] = sample_q[c];
  end

  always_comb begin
    lut_phase = '0;
    if (sweep) begin
      lut_phase = phase[slot_q];
    end
  end

  // A tick that lands in the frame_done cycle sees IDLE, so back-to-back sweeps need no special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      sample_valid_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      sample_valid_q <= step;
      frame_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_SWEEP;
            slot_q  <= '0;
          end
        end
        ST_SWEEP: begin
          if (last_slot) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            frame_done_q <= 1'b1;
          end else begin
            slot_q <= slot_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          slot_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (tick && sweep) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign sample_valid = sample_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = sweep;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dds_lut_scheduler.sv
// Scoreboard bench for dds_lut_scheduler: per-edge channel model feeds an
// expectation queue that a negedge monitor drains on sample_valid/frame_done.
module tb_dds_lut_scheduler;

  localparam int NCH   = 4;
  localparam int ACC_W = 24;
  localparam int PH_W  = 14;
  localparam int SIN_W = 12;
  localparam int AW    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tick = 1'b0;
  logic [NCH-1:0]       ch_en = '0;
  logic                 cfg_we = 1'b0;
  logic                 cfg_clr = 1'b0;
  logic [AW-1:0]        cfg_addr = '0;
  logic [ACC_W-1:0]     cfg_data = '0;
  logic                 ovr_clr = 1'b0;
  logic [PH_W-1:0]      lut_phase;
  logic [SIN_W-1:0]     lut_sine;
  logic [NCH*SIN_W-1:0] sample_data;
  logic [NCH-1:0]       sample_valid;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;

  dds_lut_scheduler #(
    .NCH   (NCH),
    .ACC_W (ACC_W),
    .PH_W  (PH_W),
    .SIN_W (SIN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .ch_en        (ch_en),
    .cfg_we       (cfg_we),
    .cfg_clr      (cfg_clr),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .ovr_clr      (ovr_clr),
    .lut_phase    (lut_phase),
    .lut_sine     (lut_sine),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Stand-in LUT: any phase-dependent function exposes the phase the DUT used.
  function automatic logic [SIN_W-1:0] lut_f(input logic [PH_W-1:0] p);
    int v;
    v = (int'(p) * 37) ^ (int'(p) >> 5);
    return SIN_W'(v);
  endfunction

  always_comb lut_sine = lut_f(lut_phase);

  typedef struct {
    bit               frame;
    int               ch;
    logic [SIN_W-1:0] val;
  } exp_t;

  exp_t             q[$];
  logic [ACC_W-1:0] acc_m [NCH];
  logic [ACC_W-1:0] ftw_m [NCH];
  int               busy_cnt;
  bit               ovr_m;
  int               checks;
  int               errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      acc_m[i] = '0;
      ftw_m[i] = '0;
    end
    busy_cnt = 0;
    ovr_m    = 1'b0;
    q.delete();
  endtask

  // Called at posedge+1: checks state after the previous edge, then drives and
  // advances the model for the coming edge.
  task automatic cyc(input bit t, input bit we, input bit clr, input bit oc,
                     input int addr, input logic [ACC_W-1:0] data,
                     input logic [NCH-1:0] en);
    int  s;
    bit  ovr_set;
    logic [PH_W-1:0] ph_exp;
    ph_exp = '0;
    if (busy_cnt > 0) ph_exp = acc_m[NCH - busy_cnt][ACC_W-1 -: PH_W];
    check("busy", busy, (busy_cnt > 0));
    check("overrun", overrun, ovr_m);
    check("lut_phase", lut_phase, ph_exp);

    tick     = t;
    cfg_we   = we;
    cfg_clr  = clr;
    ovr_clr  = oc;
    cfg_addr = AW'(addr);
    cfg_data = data;
    ch_en    = en;

    ovr_set = 1'b0;
    if (busy_cnt > 0) begin
      s = NCH - busy_cnt;
      if (en[s]) begin
        q.push_back('{frame: 1'b0, ch: s, val: lut_f(acc_m[s][ACC_W-1 -: PH_W])});
        acc_m[s] = acc_m[s] + ftw_m[s];
      end
      if (busy_cnt == 1) q.push_back('{frame: 1'b1, ch: 0, val: '0});
      busy_cnt--;
      if (t) ovr_set = 1'b1;
    end else if (t) begin
      busy_cnt = NCH;
    end
    if (clr) acc_m[addr] = '0;
    if (we)  ftw_m[addr] = data;
    if (ovr_set)  ovr_m = 1'b1;
    else if (oc)  ovr_m = 1'b0;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0, en);
  endtask

  task automatic check_reset_outputs();
    check("rst_sample_data", sample_data, '0);
    check("rst_sample_valid", sample_valid, '0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_lut_phase", lut_phase, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid != '0) begin
        if (q.size() == 0 || q[0].frame) begin
          check("unexpected_sample_valid", sample_valid, '0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sample_valid_chan", sample_valid, (64'd1 << e.ch));
          check("sample_value", sample_data[e.ch*SIN_W +: SIN_W], e.val);
        end
      end
      if (frame_done) begin
        if (q.size() == 0 || !q[0].frame) begin
          check("unexpected_frame_done", frame_done, 0);
        end else begin
          void'(q.pop_front());
          check("frame_done", frame_done, 1);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    model_reset();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single channel, three ticks: slot-0 phase steps 0,1,2.
    cyc(0, 1, 0, 0, 0, 24'h000400, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 0, '0, 4'b0001);
      idle(NCH + 1, 4'b0001);
    end

    // All channels, one sweep.
    cyc(0, 1, 0, 0, 1, 24'h012345, 4'b1111);
    cyc(0, 1, 0, 0, 2, 24'h2A0001, 4'b1111);
    cyc(0, 1, 0, 0, 3, 24'h700F00, 4'b1111);
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    idle(NCH + 2, 4'b1111);

    // Tick while busy sets overrun; ovr_clr clears; set wins over clear.
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    cyc(0, 0, 0, 0, 0, '0, 4'b1111);
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    idle(NCH, 4'b1111);
    cyc(0, 0, 0, 1, 0, '0, 4'b1111);
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    cyc(1, 0, 0, 1, 0, '0, 4'b1111);
    idle(NCH, 4'b1111);
    cyc(0, 0, 0, 1, 0, '0, 4'b1111);

    // Back-to-back: second tick in the frame_done cycle.
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    idle(NCH, 4'b1111);
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    idle(NCH + 1, 4'b1111);

    // Channel 1 with all-ones FTW: wraps silently.
    cyc(0, 1, 1, 0, 1, 24'hFFFFFF, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 0, '0, 4'b0010);
      idle(NCH + 1, 4'b0010);
    end

    // Clear and write channel 2 on its own accumulate edge (E3).
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    cyc(0, 0, 0, 0, 0, '0, 4'b1111);
    cyc(0, 0, 0, 0, 0, '0, 4'b1111);
    cyc(0, 1, 1, 0, 2, 24'h155555, 4'b1111);
    idle(NCH, 4'b1111);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 0, 0, 0, '0, 4'b1111);
      idle(NCH + 1, 4'b1111);
    end

    // Reset at E2 of a sweep aborts it.
    cyc(1, 0, 0, 0, 0, '0, 4'b1111);
    cyc(0, 0, 0, 0, 0, '0, 4'b1111);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(NCH + 2, 4'b1111);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, NCH - 1)), ACC_W'($urandom),
          NCH'($urandom));
    end
    idle(NCH + 3, 4'b1111);

    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
